// File: rtl/c3_relu_pool_writer.sv
// C3 output stage: ReLU on the per-kernel inner-product stream, 2x2/stride-2 max pooling
// through a per-column partial-max buffer, and S4 feature-memory write address generation.
module c3_relu_pool_writer #(
  parameter int unsigned OUT_W = 10,
  parameter int unsigned OUT_H = 10,
  parameter int unsigned NUM_K = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [7:0]    in_kidx,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [15:0]   out_addr,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);

  localparam int unsigned KW     = (NUM_K > 1) ? $clog2(NUM_K) : 1;
  localparam int unsigned CW     = $clog2(OUT_W);
  localparam int unsigned RW     = $clog2(OUT_H);
  localparam int unsigned HALF_W = OUT_W / 2;
  localparam int unsigned BUF_N  = HALF_W * NUM_K;
  localparam int unsigned IW     = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [15:0]     out_addr_q, out_addr_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;

  logic [DW-1:0]   buf_mem [BUF_N];
  logic            buf_we;
  logic [DW-1:0]   buf_wdata;
  logic [IW-1:0]   buf_idx;
  logic [DW-1:0]   buf_rd;

  logic            accept;
  logic            last_beat;
  logic [KW-1:0]   k_e;
  logic [CW-1:0]   c_e;
  logic [RW-1:0]   r_e;
  logic [DW-1:0]   relu_v;
  logic [DW-1:0]   max_v;
  logic [15:0]     addr_v;

  // A start pulse re-bases the stream, so the same-cycle beat is position (0,0,0).
  assign k_e       = start ? '0 : k_q;
  assign c_e       = start ? '0 : c_q;
  assign r_e       = start ? '0 : r_q;
  assign accept    = in_valid && (start || (state_q == RUN));
  assign last_beat = (k_e == KW'(NUM_K - 1)) && (c_e == CW'(OUT_W - 1)) && (r_e == RW'(OUT_H - 1));

  assign relu_v  = in_data[DW-1] ? '0 : in_data;
  assign buf_idx = IW'(32'(c_e >> 1) * NUM_K + 32'(k_e));
  assign buf_rd  = buf_mem[buf_idx];
  assign max_v   = (buf_rd > relu_v) ? buf_rd : relu_v;
  assign addr_v  = 16'((32'(r_e >> 1) * HALF_W + 32'(c_e >> 1)) * NUM_K + 32'(k_e));

  // Next-state, counter, pooling and output logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    r_d          = r_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    buf_we       = 1'b0;
    buf_wdata    = relu_v;

    if (start) begin
      state_d = RUN;
      k_d     = '0;
      c_d     = '0;
      r_d     = '0;
      err_d   = 1'b0;
    end

    if (accept) begin
      if (32'(in_kidx) != 32'(k_e)) begin
        err_d = 1'b1;
      end

      if (!r_e[0] && !c_e[0]) begin
        buf_we    = 1'b1;
        buf_wdata = relu_v;
      end else if (r_e[0] && c_e[0]) begin
        out_valid_d = 1'b1;
        out_data_d  = max_v;
        out_addr_d  = addr_v;
      end else begin
        buf_we    = 1'b1;
        buf_wdata = max_v;
      end

      if (k_e == KW'(NUM_K - 1)) begin
        k_d = '0;
        if (c_e == CW'(OUT_W - 1)) begin
          c_d = '0;
          r_d = (r_e == RW'(OUT_H - 1)) ? '0 : r_e + RW'(1);
        end else begin
          c_d = c_e + CW'(1);
        end
      end else begin
        k_d = k_e + KW'(1);
      end

      if (last_beat) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      c_q          <= '0;
      r_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      c_q          <= c_d;
      r_q          <= r_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Partial-max buffer; contents need no reset since even/even always opens a window first.
  always_ff @(posedge clk) begin
    if (buf_we && !rst) begin
      buf_mem[buf_idx] <= buf_wdata;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_c3_relu_pool_writer.sv
// Bench for c3_relu_pool_writer: frame-level table plus abort/reset sequences, all outputs
// scored against a model that stores the whole C3 map and pools it with plain arithmetic.
module tb_c3_relu_pool_writer;

  localparam int W     = 10;
  localparam int H     = 10;
  localparam int K     = 16;
  localparam int NOUT  = (W / 2) * (H / 2) * K;
  localparam int NBEAT = W * H * K;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  in_kidx = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] out_addr;
  logic        busy;
  logic        frame_done;
  logic        err;

  c3_relu_pool_writer #(.OUT_W(W), .OUT_H(H), .NUM_K(K), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_kidx(in_kidx), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; bit last; } exp_t;
  typedef struct { int mode; int base; int gap; int bad; bit chk;
                   int e0; int e3; int e16; int elast; int eerr; } vec_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   feat [H][W][K];
  int   obs [NOUT];
  int   pos = 0;
  bit   running = 0;
  int   fd_cnt = 0;
  int   n_out = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int relu(input logic [15:0] d);
    return d[15] ? 0 : int'(d);
  endfunction

  function automatic logic [15:0] gen(input int mode, input int base, input int b);
    int r = b / (W * K);
    int c = (b / K) % W;
    int k = b % K;
    case (mode)
      0:       return 16'(base + r * 10 + c);
      1:       return (r == 1 && c == 1 && k == 3) ? 16'd5 : 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_start();
    pos     = 0;
    running = 1;
  endtask

  // Stores the ReLU'd map; a beat that completes a 2x2 window produces its maximum.
  task automatic model_beat(input logic [15:0] d, input int ecyc);
    int r, c, k, m;
    exp_t e;
    if (!running) return;
    r = pos / (W * K);
    c = (pos / K) % W;
    k = pos % K;
    feat[r][c][k] = relu(d);
    if (r % 2 == 1 && c % 2 == 1) begin
      m = 0;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (feat[r-dr][c-dc][k] > m) m = feat[r-dr][c-dc][k];
      e.addr = ((r / 2) * (W / 2) + c / 2) * K + k;
      e.data = m;
      e.cyc  = ecyc;
      e.last = (pos == NBEAT - 1);
      expq.push_back(e);
    end
    pos++;
    if (pos == NBEAT) running = 0;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_out++;
      if (expq.size() == 0) begin
        check("unexpected_out_valid", int'(out_valid), 0);
      end else begin
        mon_e = expq.pop_front();
        check("out_addr", int'(out_addr), mon_e.addr);
        check("out_data", int'(out_data), mon_e.data);
        check("out_latency_cycle", cyc, mon_e.cyc);
        check("frame_done_with_out", int'(frame_done), int'(mon_e.last));
        if (int'(out_addr) < NOUT) obs[out_addr] = int'(out_data);
      end
    end else if (frame_done !== 1'b0) begin
      check("frame_done_alone", int'(frame_done), 0);
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit st, input logic [15:0] d, input logic [7:0] ki,
                           input int gap, output int ecyc);
    while (int'($urandom_range(99)) < gap) idle_cycle();
    start    = st;
    in_valid = 1'b1;
    in_data  = d;
    in_kidx  = ki;
    ecyc     = cyc + 1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int base, input int gap, input int bad,
                           input bit sw, input int nb);
    int ec;
    logic [15:0] d;
    logic [7:0]  ki;
    bit st;
    if (!sw) begin
      start = 1'b1;
      idle_cycle();
      start = 1'b0;
      model_start();
      check("busy_after_start", int'(busy), 1);
      check("err_cleared_by_start", int'(err), 0);
    end
    for (int b = 0; b < nb; b++) begin
      st = sw && (b == 0);
      if (st) model_start();
      d  = gen(mode, base, b);
      ki = (b == bad) ? 8'd9 : 8'(b % K);
      send_beat(st, d, ki, gap, ec);
      model_beat(d, ec);
      if (bad >= 0 && b == bad - 1) check("err_before_bad_beat", int'(err), 0);
      if (bad >= 0 && b == bad)     check("err_after_bad_beat", int'(err), 1);
    end
  endtask

  task automatic drain();
    repeat (3) idle_cycle();
    check("expected_outputs_drained", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    vec_t tbl[5];
    int ec;

    // mode: 0 ramp r*10+c+base, 1 ReLU pattern, 2 random data
    tbl[0] = '{0, 0, 0, -1, 1, 11, 11, 13, 99, 0};
    tbl[1] = '{1, 0, 0, -1, 1, 0, 5, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 7, 1, 11, 11, 13, 99, 1};
    tbl[3] = '{0, 0, 50, -1, 1, 11, 11, 13, 99, 0};
    tbl[4] = '{2, 0, 30, -1, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int t = 0; t < 5; t++) begin
      fd_cnt = 0;
      n_out  = 0;
      run_frame(tbl[t].mode, tbl[t].base, tbl[t].gap, tbl[t].bad, 1'b0, NBEAT);
      drain();
      check("frame_done_count", fd_cnt, 1);
      check("output_count", n_out, NOUT);
      check("busy_after_frame", int'(busy), 0);
      check("err_at_frame_end", int'(err), tbl[t].eerr);
      if (tbl[t].chk) begin
        check("addr0_data", obs[0], tbl[t].e0);
        check("addr3_data", obs[3], tbl[t].e3);
        check("addr16_data", obs[16], tbl[t].e16);
        check("last_addr_data", obs[NOUT-1], tbl[t].elast);
      end
    end

    // Abort frame A at beat 500 with a start that also carries B's first beat.
    fd_cnt = 0;
    run_frame(0, 0, 0, -1, 1'b0, 500);
    check("abort_no_frame_done_for_a", fd_cnt, 0);
    run_frame(0, 1000, 0, -1, 1'b1, NBEAT);
    drain();
    check("abort_frame_done_count", fd_cnt, 1);
    check("abort_addr0_data", obs[0], 1011);
    check("abort_addr16_data", obs[16], 1013);
    check("abort_last_data", obs[NOUT-1], 1099);

    // Reset mid-frame, then beats without start must be ignored.
    run_frame(0, 0, 0, -1, 1'b0, 60);
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    running = 0;
    expq.delete();
    check_reset_outputs("midrst");
    n_out = 0;
    for (int b = 0; b < 200; b++) send_beat(1'b0, gen(0, 0, b), 8'(b % K), 0, ec);
    drain();
    check("idle_beats_no_output", n_out, 0);
    check("idle_beats_busy", int'(busy), 0);
    check("idle_beats_out_data", int'(out_data), 0);

    fd_cnt = 0;
    n_out  = 0;
    run_frame(0, 0, 0, -1, 1'b0, NBEAT);
    drain();
    check("post_rst_frame_done_count", fd_cnt, 1);
    check("post_rst_output_count", n_out, NOUT);
    check("post_rst_addr0_data", obs[0], 11);
    check("post_rst_addr16_data", obs[16], 13);
    check("post_rst_last_data", obs[NOUT-1], 99);
    check("post_rst_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
